uart_tx_fifo_cfg: RTL and testbench

Parametrised, runtime-configurable UART transmitter with an integrated transmit FIFO. It is the next-generation serial output path of the voltmeter: the host logic pushes words over a valid/ready handshake, and the block serialises them onto `tx`. Baud divisor, parity and stop-bit count are run-time inputs, latched per frame. It replaces the fixed-format tx path and exports FIFO fill level and busy status.

---
 rtl/uart_pkg.sv | 7 +
 rtl/uart_baud_gen.sv | 17 +
 rtl/uart_tx_fifo_cfg.sv | 118 +++++++++++
 tb/tb_uart_tx_fifo_cfg.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM state type and parity mode encodings for the UART tx path
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} uart_state_t;
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: ticks once every period clk cycles (0 behaves as 1); restart realigns the count
module uart_baud_gen #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         restart,
  input  logic [W-1:0] period,
  output logic         tick
);
  logic [W-1:0] cnt;
  logic [W-1:0] last;
  assign last = (period == '0) ? '0 : period - 1'b1;
  assign tick = cnt >= last;
  always_ff @(posedge clk)
    cnt <= (rst || restart || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_tx_fifo_cfg.sv
// uart_tx_fifo_cfg: UART transmitter with inline tx FIFO and per-frame latched config.
// Parity generation and the PAR state exist only when UART_TX_PARITY_EN is defined.
module uart_tx_fifo_cfg
  import uart_pkg::*;
#(
  parameter int DBIT   = 8,
  parameter int OVS    = 16,
  parameter int DVSR_W = 16,
  parameter int FIFO_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DVSR_W-1:0] dvsr,
  input  logic [1:0]        parity_mode,
  input  logic              stop2,
  input  logic              wr_valid,
  input  logic [DBIT-1:0]   wr_data,
  output logic              wr_ready,
  output logic [FIFO_W:0]   fifo_level,
  output logic              tx,
  output logic              tx_busy,
  output logic              tx_done_tick
);
  localparam int DEPTH = 2**FIFO_W;
  localparam int SW = $clog2(2*OVS);
  localparam int NW = $clog2(DBIT);
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  logic [DBIT-1:0] mem [DEPTH];
  logic [FIFO_W-1:0] wp, rp;
  logic [FIFO_W:0] level;
  uart_state_t state;
  logic [SW-1:0] s;
  logic [NW-1:0] n;
  logic [DBIT-1:0] sh;
  logic [DVSR_W-1:0] dvsr_l;
  logic stop2_l, par_on, pbit, tick, full, empty, push, pop, bit_end, stop_end;
  assign full = level == (FIFO_W+1)'(DEPTH);
  assign empty = level == '0;
  assign push = wr_valid && !full;
  assign bit_end = tick && s == SW'(OVS-1);
  assign stop_end = tick && s == (stop2_l ? SW'(2*OVS-1) : SW'(OVS-1));
  assign tx_done_tick = state == STOP && stop_end;
  // the last stop cycle pops directly so the next start bit follows with no gap
  assign pop = !empty && (state == IDLE || tx_done_tick);
  assign wr_ready = !full;
  assign fifo_level = level;
  assign tx_busy = state != IDLE;
  uart_baud_gen #(.W(DVSR_W)) baud (
    .clk(clk),
    .rst(rst),
    .restart(pop),
    .period(dvsr_l),
    .tick(tick)
  );
  always_ff @(posedge clk)
    if (push) mem[wp] <= wr_data;
  always_ff @(posedge clk)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      level <= '0;
    end else begin
      wp <= wp + FIFO_W'(push);
      rp <= rp + FIFO_W'(pop);
      level <= level + (FIFO_W+1)'(push) - (FIFO_W+1)'(pop);
    end
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      tx <= 1'b1;
      s <= '0;
      n <= '0;
      sh <= '0;
      dvsr_l <= '0;
      stop2_l <= 1'b0;
      par_on <= 1'b0;
      pbit <= 1'b0;
    end else if (pop) begin
      state <= START;
      tx <= 1'b0;
      s <= '0;
      sh <= mem[rp];
      dvsr_l <= dvsr;
      stop2_l <= stop2;
      par_on <= PAR_EN && (parity_mode == PAR_EVEN || parity_mode == PAR_ODD);
      pbit <= ^mem[rp] ^ (parity_mode == PAR_ODD);
    end else if (tick && state != IDLE) begin
      s <= ((bit_end && state != STOP) || stop_end) ? '0 : s + 1'b1;
      case (state)
        START: if (bit_end) begin
          state <= DATA;
          tx <= sh[0];
          n <= '0;
        end
        DATA: if (bit_end) begin
          sh <= sh >> 1;
          n <= n + 1'b1;
          if (n == NW'(DBIT-1)) begin
            state <= par_on ? PAR : STOP;
            tx <= par_on ? pbit : 1'b1;
          end else
            tx <= sh[1];
        end
`ifdef UART_TX_PARITY_EN
        PAR: if (bit_end) begin
          state <= STOP;
          tx <= 1'b1;
        end
`endif
        STOP: if (stop_end) state <= IDLE;
        default: ;
      endcase
    end
endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// tb_uart_tx_fifo_cfg: directed and random stimulus checked against a frame-level reference model
`timescale 1ns/1ps
module tb_uart_tx_fifo_cfg;
  localparam int DBIT = 8, OVS = 16, DVSR_W = 16, FIFO_W = 4, DEPTH = 16;
`ifdef UART_TX_PARITY_EN
  localparam bit PEN = 1'b1;
`else
  localparam bit PEN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, stop2 = 1'b0, wr_valid = 1'b0;
  logic [DVSR_W-1:0] dvsr = 16'd1;
  logic [1:0] parity_mode = 2'b00;
  logic [DBIT-1:0] wr_data = '0;
  logic wr_ready, tx, tx_busy, tx_done_tick;
  logic [FIFO_W:0] fifo_level;
  int total = 0, bad = 0, cyc = 0, done_cnt = 0, t0 = 0, d0 = 0;
  bit chk_en = 1'b0;
  always #5 clk = ~clk;
  uart_tx_fifo_cfg #(.DBIT(DBIT), .OVS(OVS), .DVSR_W(DVSR_W), .FIFO_W(FIFO_W)) dut (
    .clk(clk), .rst(rst), .dvsr(dvsr), .parity_mode(parity_mode), .stop2(stop2),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready), .fifo_level(fifo_level),
    .tx(tx), .tx_busy(tx_busy), .tx_done_tick(tx_done_tick)
  );
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask
  // reference model: a word queue plus the frame in flight as (word, bit length, position)
  logic [DBIT-1:0] q[$];
  logic [DBIT-1:0] m_w;
  bit m_act = 1'b0, m_par = 1'b0, m_pbit = 1'b0, m_push = 1'b0;
  int m_pos = 0, m_len = 1, m_bl = 1;
  function automatic int m_tx();
    int k;
    if (!m_act) return 1;
    k = m_pos / m_bl;
    if (k == 0) return 0;
    if (k <= DBIT) return int'(m_w[k-1]);
    if (k == DBIT + 1 && m_par) return int'(m_pbit);
    return 1;
  endfunction
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      m_act = 1'b0;
    end else begin
      m_push = wr_valid && q.size() < DEPTH;
      if (m_act) begin
        m_pos++;
        if (m_pos == m_len) m_act = 1'b0;
      end
      if (!m_act && q.size() > 0) begin
        m_w = q.pop_front();
        m_bl = (dvsr == 0 ? 1 : int'(dvsr)) * OVS;
        m_par = PEN && (parity_mode == 2'b01 || parity_mode == 2'b10);
        m_pbit = (^m_w) ^ (parity_mode == 2'b10);
        m_len = m_bl * (1 + DBIT + int'(m_par) + (stop2 ? 2 : 1));
        m_pos = 0;
        m_act = 1'b1;
      end
      if (m_push) q.push_back(wr_data);
    end
  end
  always @(negedge clk) if (chk_en) begin
    check("tx", tx, m_tx());
    check("busy", tx_busy, m_act);
    check("done", tx_done_tick, m_act && m_pos == m_len - 1);
    check("level", fifo_level, q.size());
    check("wr_ready", wr_ready, q.size() < DEPTH);
  end
  always @(negedge clk) if (tx_done_tick === 1'b1) done_cnt++;
  task automatic step(input int k = 1);
    repeat (k) @(negedge clk);
  endtask
  task automatic write(input logic [DBIT-1:0] w);
    wr_valid = 1'b1;
    wr_data = w;
    step();
    wr_valid = 1'b0;
  endtask
  task automatic at(input int o);
    while (cyc < t0 + o) step();
  endtask
  task automatic wait_fall(input string name);
    int k = 0;
    while (tx !== 1'b0 && k < 5000) begin step(); k++; end
    check(name, k < 5000, 1);
    t0 = cyc;
  endtask
  task automatic wait_done(input string name);
    int k = 0;
    while (tx_done_tick !== 1'b1 && k < 5000) begin step(); k++; end
    check(name, k < 5000, 1);
  endtask
  task automatic wait_idle(input string name);
    int k = 0;
    while ((tx_busy !== 1'b0 || fifo_level != 0) && k < 20000) begin step(); k++; end
    check(name, k < 20000, 1);
  endtask
  initial begin
    logic [9:0] f;
    step();
    chk_en = 1'b1;
    check("rst_tx", tx, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_level", fifo_level, 0);
    check("rst_ready", wr_ready, 1);
    check("rst_done", tx_done_tick, 0);
    step(2);
    rst = 1'b0;
    step(2);
    // single 0xA5 frame, dvsr=4: 64 cycles per bit
    dvsr = 4;
    d0 = done_cnt;
    write(8'hA5);
    check("t1_level", fifo_level, 1);
    wait_fall("t1_fall");
    check("t1_busy", tx_busy, 1);
    f = 10'b1_10100101_0;
    at(32); check("t1_start_mid", tx, 0);
    at(63); check("t1_start_end", tx, 0);
    at(64); check("t1_bit0_first", tx, 1);
    for (int k = 1; k < 10; k++) begin
      at(64 * k + 32);
      check("t1_bit", tx, int'(f[k]));
    end
    wait_done("t1_done_seen");
    check("t1_done_off", cyc - t0, 639);
    step(5);
    check("t1_done_cnt", done_cnt - d0, 1);
    wait_idle("t1_idle");
    // dvsr=0 behaves like dvsr=1
    for (int v = 0; v < 2; v++) begin
      dvsr = 16'(v);
      write(8'h35);
      wait_fall("dv_fall");
      at(15); check("dv_start_end", tx, 0);
      at(16); check("dv_bit0", tx, 1);
      wait_idle("dv_idle");
    end
    // parity / two stop bits; config changes mid-frame must not leak in
    dvsr = 1; stop2 = 1'b1; parity_mode = 2'b01;
    write(8'h03);
    wait_fall("p1_fall");
    at(48);
    parity_mode = 2'b10; stop2 = 1'b0; dvsr = 3;
`ifdef UART_TX_PARITY_EN
    at(16 * 9 + 8); check("p1_even_bit", tx, 0);
`endif
    wait_done("p1_done_seen");
    check("p1_done_off", cyc - t0, PEN ? 191 : 175);
    wait_idle("p1_idle");
    dvsr = 1; stop2 = 1'b1; parity_mode = 2'b10;
    write(8'h03);
    wait_fall("p2_fall");
    at(20); parity_mode = 2'b01;
`ifdef UART_TX_PARITY_EN
    at(16 * 9 + 8); check("p2_odd_bit", tx, 1);
`endif
    wait_done("p2_done_seen");
    check("p2_done_off", cyc - t0, PEN ? 191 : 175);
    wait_idle("p2_idle");
    // fill to full behind a busy transmitter, then a refused write in the pop cycle
    dvsr = 1; stop2 = 1'b0; parity_mode = 2'b00;
    write(8'($urandom));
    wait_fall("full_fall");
    for (int k = 0; k < 17; k++) begin
      wr_valid = 1'b1;
      wr_data = 8'($urandom);
      step();
    end
    check("full_level", fifo_level, 16);
    check("full_ready", wr_ready, 0);
    wr_data = 8'hEE;
    wait_done("full_pop");
    step();
    wr_valid = 1'b0;
    check("full_pop_refused", fifo_level, 15);
    begin
      int k = 0;
      while ((tx_busy !== 1'b0 || fifo_level != 0) && k < 20000) begin
        dvsr = 16'($urandom_range(0, 2));
        parity_mode = 2'($urandom);
        stop2 = 1'($urandom);
        step();
        k++;
      end
      check("full_drain", k < 20000, 1);
    end
    // push and pop in the same cycle at level 3
    dvsr = 1; stop2 = 1'b0; parity_mode = 2'b00;
    write(8'($urandom));
    wait_fall("pp_fall");
    for (int k = 0; k < 3; k++) write(8'($urandom));
    check("pp_level3", fifo_level, 3);
    wait_done("pp_pop");
    wr_valid = 1'b1;
    wr_data = 8'($urandom);
    step();
    wr_valid = 1'b0;
    check("pp_level_kept", fifo_level, 3);
    wait_idle("pp_idle");
    // random traffic and configuration
    for (int i = 0; i < 3000; i++) begin
      wr_valid = $urandom_range(0, 3) == 0;
      wr_data = 8'($urandom);
      dvsr = 16'($urandom_range(0, 2));
      parity_mode = 2'($urandom);
      stop2 = 1'($urandom);
      step();
    end
    wr_valid = 1'b0;
    wait_idle("rand_idle");
    // reset during DATA with 5 words queued
    dvsr = 2; stop2 = 1'b0; parity_mode = 2'b00;
    write(8'($urandom));
    wait_fall("rs_fall");
    for (int k = 0; k < 5; k++) write(8'($urandom));
    at(96);
    check("rs_level5", fifo_level, 5);
    d0 = done_cnt;
    rst = 1'b1;
    step();
    check("rs_tx", tx, 1);
    check("rs_busy", tx_busy, 0);
    check("rs_level", fifo_level, 0);
    check("rs_done", tx_done_tick, 0);
    rst = 1'b0;
    step(20);
    check("rs_no_done", done_cnt - d0, 0);
    check("rs_level_after", fifo_level, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
